// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller for the register file. It counts in-flight writes
// per register, stalls decode on RAW hazards, and handshakes a drain for debug access.
module reg_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int CW   = 2,
  parameter int PW   = 6
) (
  input  logic            sbi_clk,
  input  logic            sbi_rst,
  input  logic            sbi_issue_valid,
  input  logic [AW-1:0]   sbi_src1_addr,
  input  logic            sbi_src1_used,
  input  logic [AW-1:0]   sbi_src2_addr,
  input  logic            sbi_src2_used,
  input  logic [AW-1:0]   sbi_dst_addr,
  input  logic            sbi_dst_wen,
  output logic            sbo_issue_ready,
  input  logic            sbi_ret_valid,
  input  logic [AW-1:0]   sbi_ret_addr,
  input  logic            sbi_flush,
  input  logic            sbi_drain_req,
  output logic            sbo_drain_ack,
  output logic [NREG-1:0] sbo_busy_mask,
  output logic [PW-1:0]   sbo_pending,
  output logic            sbo_err
);

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] count [NREG];
  state_t        state, state_nxt;
  logic          acked;
  logic          err;
  logic          all_zero;
  logic          src1_hz, src2_hz, dst_full;
  logic          issue_fire;

  // Hazards look only at registered counts: a same-cycle retire is not bypassed.
  assign src1_hz  = sbi_src1_used && (count[sbi_src1_addr] != '0);
  assign src2_hz  = sbi_src2_used && (count[sbi_src2_addr] != '0);
  assign dst_full = sbi_dst_wen   && (count[sbi_dst_addr] == CMAX);

  assign sbo_issue_ready = (state == RUN) && !sbi_flush && !sbi_drain_req &&
                           !src1_hz && !src2_hz && !dst_full;
  assign issue_fire      = sbi_issue_valid && sbo_issue_ready && sbi_dst_wen;

  // NOTE: the counters are individual flops, not a RAM, so resetting every entry is intended.
  always_ff @(posedge sbi_clk or posedge sbi_rst) begin
    if (sbi_rst) begin
      for (int i = 0; i < NREG; i++) count[i] <= '0;
    end else if (sbi_flush) begin
      for (int i = 0; i < NREG; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: non-blocking assignments keep every counter sampling pre-edge state.
        if (issue_fire && (sbi_dst_addr == AW'(i)) &&
            !(sbi_ret_valid && (sbi_ret_addr == AW'(i))))
          count[i] <= count[i] + 1'b1;
        else if (sbi_ret_valid && (sbi_ret_addr == AW'(i)) &&
                 !(issue_fire && (sbi_dst_addr == AW'(i))) && (count[i] != '0))
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Underflow is sticky; a flush discards the cycle's retires, so it cannot raise it.
  always_ff @(posedge sbi_clk or posedge sbi_rst) begin
    if (sbi_rst)
      err <= 1'b0;
    else if (!sbi_flush && sbi_ret_valid && (count[sbi_ret_addr] == '0))
      err <= 1'b1;
  end

  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a latch behind.
    sbo_pending   = '0;
    sbo_busy_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      sbo_pending      = sbo_pending + PW'(count[i]);
      sbo_busy_mask[i] = (count[i] != '0);
    end
  end

  assign all_zero = (sbo_busy_mask == '0);

  always_ff @(posedge sbi_clk or posedge sbi_rst) begin
    if (sbi_rst) begin
      state <= RUN;
      acked <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!sbi_drain_req)
        acked <= 1'b0;
      else if (state == ACK)
        acked <= 1'b1;
    end
  end

  // A held request re-enters DRAIN already acked, so the pulse is not repeated.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (sbi_drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!sbi_drain_req)          state_nxt = RUN;
        else if (all_zero && !acked) state_nxt = ACK;
      end
      ACK:     state_nxt = sbi_drain_req ? DRAIN : RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign sbo_drain_ack = (state == ACK);
  assign sbo_err       = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: expected post-edge state is queued as each
// step is driven and popped for comparison after the clock edge.
module tb_reg_scoreboard;

  logic        sbi_clk, sbi_rst;
  logic        sbi_issue_valid, sbi_src1_used, sbi_src2_used, sbi_dst_wen;
  logic [3:0]  sbi_src1_addr, sbi_src2_addr, sbi_dst_addr, sbi_ret_addr;
  logic        sbi_ret_valid, sbi_flush, sbi_drain_req;
  logic        sbo_issue_ready, sbo_drain_ack, sbo_err;
  logic [15:0] sbo_busy_mask;
  logic [5:0]  sbo_pending;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] busy;
    logic [5:0]  pend;
    logic        err;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  reg_scoreboard dut (
    .sbi_clk(sbi_clk), .sbi_rst(sbi_rst),
    .sbi_issue_valid(sbi_issue_valid),
    .sbi_src1_addr(sbi_src1_addr), .sbi_src1_used(sbi_src1_used),
    .sbi_src2_addr(sbi_src2_addr), .sbi_src2_used(sbi_src2_used),
    .sbi_dst_addr(sbi_dst_addr), .sbi_dst_wen(sbi_dst_wen),
    .sbo_issue_ready(sbo_issue_ready),
    .sbi_ret_valid(sbi_ret_valid), .sbi_ret_addr(sbi_ret_addr),
    .sbi_flush(sbi_flush), .sbi_drain_req(sbi_drain_req),
    .sbo_drain_ack(sbo_drain_ack), .sbo_busy_mask(sbo_busy_mask),
    .sbo_pending(sbo_pending), .sbo_err(sbo_err)
  );

  initial begin
    sbi_clk = 1'b0;
    forever #5 sbi_clk = ~sbi_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sbi_issue_valid = 1'b0; sbi_src1_used = 1'b0; sbi_src2_used = 1'b0;
    sbi_dst_wen = 1'b0; sbi_ret_valid = 1'b0; sbi_flush = 1'b0;
    sbi_src1_addr = '0; sbi_src2_addr = '0; sbi_dst_addr = '0; sbi_ret_addr = '0;
  endtask

  task automatic issue(input logic [3:0] s1, input logic s1u, input logic [3:0] d, input logic dw);
    sbi_issue_valid = 1'b1;
    sbi_src1_addr = s1; sbi_src1_used = s1u;
    sbi_dst_addr = d; sbi_dst_wen = dw;
  endtask

  task automatic retire(input logic [3:0] a);
    sbi_ret_valid = 1'b1;
    sbi_ret_addr  = a;
  endtask

  task automatic ready_is(input string tag, input logic exp);
    #1;
    chk({tag, " ready"}, {31'd0, sbo_issue_ready}, {31'd0, exp});
  endtask

  task automatic expect_post(input string tag, input logic [15:0] busy, input logic [5:0] pend,
                             input logic err, input logic ack);
    exp_t e;
    e.tag = tag; e.busy = busy; e.pend = pend; e.err = err; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge sbi_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, " busy"}, {16'd0, sbo_busy_mask}, {16'd0, e.busy});
      chk({e.tag, " pend"}, {26'd0, sbo_pending},   {26'd0, e.pend});
      chk({e.tag, " err"},  {31'd0, sbo_err},       {31'd0, e.err});
      chk({e.tag, " ack"},  {31'd0, sbo_drain_ack}, {31'd0, e.ack});
    end
    idle();
  endtask

  initial begin
    sbi_rst = 1'b1;
    sbi_drain_req = 1'b0;
    idle();
    #12;
    chk("rst busy", {16'd0, sbo_busy_mask}, 32'h0);
    chk("rst pend", {26'd0, sbo_pending}, 32'h0);
    chk("rst err",  {31'd0, sbo_err}, 32'h0);
    chk("rst ack",  {31'd0, sbo_drain_ack}, 32'h0);
    ready_is("rst", 1'b1);
    @(negedge sbi_clk);
    sbi_rst = 1'b0;
    @(posedge sbi_clk);
    #1;

    // RAW hazard on r3, no same-cycle bypass of the retire
    issue(4'd0, 1'b0, 4'd3, 1'b1); ready_is("raw w3", 1'b1);
    expect_post("raw w3", 16'h0008, 6'd1, 1'b0, 1'b0); tick();
    issue(4'd3, 1'b1, 4'd0, 1'b0); ready_is("raw r3 stall", 1'b0);
    expect_post("raw r3 stall", 16'h0008, 6'd1, 1'b0, 1'b0); tick();
    issue(4'd3, 1'b1, 4'd0, 1'b0); retire(4'd3); ready_is("raw nobypass", 1'b0);
    expect_post("raw ret3", 16'h0000, 6'd0, 1'b0, 1'b0); tick();
    issue(4'd3, 1'b1, 4'd0, 1'b0); ready_is("raw r3 go", 1'b1);
    expect_post("raw r3 go", 16'h0000, 6'd0, 1'b0, 1'b0); tick();

    // saturation of r5 at three outstanding writes
    for (int k = 1; k <= 3; k++) begin
      issue(4'd0, 1'b0, 4'd5, 1'b1); ready_is("sat w5", 1'b1);
      expect_post("sat w5", 16'h0020, 6'(k), 1'b0, 1'b0); tick();
    end
    issue(4'd0, 1'b0, 4'd5, 1'b1); ready_is("sat full", 1'b0);
    expect_post("sat full", 16'h0020, 6'd3, 1'b0, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd5, 1'b1); retire(4'd5); ready_is("sat full+ret", 1'b0);
    expect_post("sat ret5", 16'h0020, 6'd2, 1'b0, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd5, 1'b1); ready_is("sat 4th", 1'b1);
    expect_post("sat 4th", 16'h0020, 6'd3, 1'b0, 1'b0); tick();
    for (int k = 2; k >= 0; k--) begin
      retire(4'd5);
      expect_post("sat drainr5", (k == 0) ? 16'h0000 : 16'h0020, 6'(k), 1'b0, 1'b0); tick();
    end

    // same-cycle issue and retire to r7
    issue(4'd0, 1'b0, 4'd7, 1'b1);
    expect_post("same w7", 16'h0080, 6'd1, 1'b0, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd7, 1'b1); retire(4'd7); ready_is("same both", 1'b1);
    expect_post("same both", 16'h0080, 6'd1, 1'b0, 1'b0); tick();
    retire(4'd7);
    expect_post("same ret7", 16'h0000, 6'd0, 1'b0, 1'b0); tick();

    // underflow is sticky until reset
    retire(4'd2);
    expect_post("uflow r2", 16'h0000, 6'd0, 1'b1, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd1, 1'b1);
    expect_post("uflow hold1", 16'h0002, 6'd1, 1'b1, 1'b0); tick();
    retire(4'd1);
    expect_post("uflow hold2", 16'h0000, 6'd0, 1'b1, 1'b0); tick();
    sbi_rst = 1'b1; #1;
    chk("uflow rst err", {31'd0, sbo_err}, 32'h0);
    sbi_rst = 1'b0;
    @(posedge sbi_clk); #1;

    // drain handshake with pending writes on r1 and r4
    issue(4'd0, 1'b0, 4'd1, 1'b1);
    expect_post("drn w1", 16'h0002, 6'd1, 1'b0, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd4, 1'b1);
    expect_post("drn w4", 16'h0012, 6'd2, 1'b0, 1'b0); tick();
    sbi_drain_req = 1'b1;
    issue(4'd0, 1'b0, 4'd6, 1'b1); ready_is("drn req", 1'b0);
    expect_post("drn req", 16'h0012, 6'd2, 1'b0, 1'b0); tick();
    retire(4'd1); ready_is("drn wait", 1'b0);
    expect_post("drn ret1", 16'h0010, 6'd1, 1'b0, 1'b0); tick();
    retire(4'd4);
    expect_post("drn ret4", 16'h0000, 6'd0, 1'b0, 1'b0); tick();
    issue(4'd0, 1'b0, 4'd6, 1'b1); ready_is("drn zero", 1'b0);
    expect_post("drn ack", 16'h0000, 6'd0, 1'b0, 1'b1); tick();
    for (int k = 0; k < 5; k++) begin
      ready_is("drn held", 1'b0);
      expect_post("drn held", 16'h0000, 6'd0, 1'b0, 1'b0); tick();
    end
    sbi_drain_req = 1'b0; ready_is("drn drop", 1'b0);
    expect_post("drn drop", 16'h0000, 6'd0, 1'b0, 1'b0); tick();
    ready_is("drn resume", 1'b1);

    // flush with a valid issue and a bogus retire in the same cycle
    for (int k = 1; k <= 4; k++) begin
      issue(4'd0, 1'b0, 4'(k), 1'b1);
      expect_post("fl fill", 16'h001E >> (4 - k) & 16'h001E, 6'(k), 1'b0, 1'b0); tick();
    end
    issue(4'd0, 1'b0, 4'd5, 1'b1); retire(4'd9); sbi_flush = 1'b1;
    ready_is("fl issue", 1'b0);
    expect_post("fl done", 16'h0000, 6'd0, 1'b0, 1'b0); tick();

    // async reset in the middle of a drain
    issue(4'd0, 1'b0, 4'd1, 1'b1);
    expect_post("rd w1", 16'h0002, 6'd1, 1'b0, 1'b0); tick();
    sbi_drain_req = 1'b1;
    expect_post("rd drain", 16'h0002, 6'd1, 1'b0, 1'b0); tick();
    expect_post("rd wait", 16'h0002, 6'd1, 1'b0, 1'b0); tick();
    #2;
    sbi_drain_req = 1'b0;
    sbi_rst = 1'b1; #1;
    chk("rd rst ack",  {31'd0, sbo_drain_ack}, 32'h0);
    chk("rd rst pend", {26'd0, sbo_pending}, 32'h0);
    chk("rd rst ready", {31'd0, sbo_issue_ready}, 32'h1);
    sbi_rst = 1'b0;
    @(posedge sbi_clk); #1;

    chk("queue empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
